// File: rtl/prv664_disp_pkg.sv
// Shared definitions for the dispatch/issue controller.
// Contents: default sizing, execution-unit index constants, issue-register
// payload struct and a register-index decode helper.
package prv664_disp_pkg;

  localparam int unsigned DEFAULT_UNITS        = 4;
  localparam int unsigned DEFAULT_MAX_INFLIGHT = 16;

  localparam int unsigned NREGS     = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned XLEN      = 32;

  // Bit positions within disp_dest
  localparam int unsigned ALU = 0;
  localparam int unsigned LSU = 1;
  localparam int unsigned MDU = 2;
  localparam int unsigned FPU = 3;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // Issue-register payload. disp_dest is kept beside it because its width
  // follows the UNITS parameter of the instantiating module.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            rs1en;
    reg_idx_t        rs1index;
    logic            rs2en;
    reg_idx_t        rs2index;
    logic            rden;
    reg_idx_t        rdindex;
    logic            frs1en;
    reg_idx_t        frs1index;
    logic            frs2en;
    reg_idx_t        frs2index;
    logic            frs3en;
    reg_idx_t        frs3index;
    logic            frden;
    reg_idx_t        frdindex;
    logic            csren;
    logic            fflagen;
  } iss_op_t;

  // One-hot register mask, all-zero when en is low
  function automatic logic [NREGS-1:0] idx_mask(input logic en, input reg_idx_t idx);
    logic [NREGS-1:0] m;
    m      = '0;
    m[idx] = en;
    return m;
  endfunction

endpackage

// File: rtl/disp_issue_ctrl_if.sv
// Decoded-instruction handshake bundle, used both for decode->dispatch and
// dispatch->execute. valid plus payload travel with the producer.
// On the issue side the dispatcher also resolves ready itself (from the
// per-unit readies), so the master modport drives ready as well.
interface pip_decode_interface
  import prv664_disp_pkg::*;
#(
  parameter int unsigned UNITS = DEFAULT_UNITS
) ();

  logic            valid;
  logic            ready;
  logic [UNITS-1:0] disp_dest;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr;
  logic            rs1en;
  reg_idx_t        rs1index;
  logic            rs2en;
  reg_idx_t        rs2index;
  logic            rden;
  reg_idx_t        rdindex;
  logic            frs1en;
  reg_idx_t        frs1index;
  logic            frs2en;
  reg_idx_t        frs2index;
  logic            frs3en;
  reg_idx_t        frs3index;
  logic            frden;
  reg_idx_t        frdindex;
  logic            csren;
  logic            fflagen;

  modport master (
    output valid, ready, disp_dest, pc, instr,
           rs1en, rs1index, rs2en, rs2index, rden, rdindex,
           frs1en, frs1index, frs2en, frs2index, frs3en, frs3index,
           frden, frdindex, csren, fflagen
  );

  modport slave (
    input  valid, disp_dest, pc, instr,
           rs1en, rs1index, rs2en, rs2index, rden, rdindex,
           frs1en, frs1index, frs2en, frs2index, frs3en, frs3index,
           frden, frdindex, csren, fflagen,
    output ready
  );

endinterface

// File: rtl/disp_scoreboard.sv
// 32-entry register busy scoreboard.
// Ports: clk, srst (synchronous clear of all bits), set_en/set_idx (mark
// busy), clr_en/clr_idx (writeback release), busy (registered vector),
// ebusy_c (busy with this cycle's writeback already removed).
module disp_scoreboard
  import prv664_disp_pkg::*;
(
  input  logic             clk,
  input  logic             srst,
  input  logic             set_en,
  input  reg_idx_t         set_idx,
  input  logic             clr_en,
  input  reg_idx_t         clr_idx,
  output logic [NREGS-1:0] busy,
  output logic [NREGS-1:0] ebusy_c
);

  logic [NREGS-1:0] set_mask_c;
  logic [NREGS-1:0] clr_mask_c;

  assign set_mask_c = idx_mask(set_en, set_idx);
  assign clr_mask_c = idx_mask(clr_en, clr_idx);

  // Writeback unblocks consumers in the same cycle
  assign ebusy_c = busy & ~clr_mask_c;

  // Set is applied after clear so a same-index set wins
  always_ff @(posedge clk) begin
    if (srst) begin
      busy <= '0;
    end else begin
      busy <= ebusy_c | set_mask_c;
    end
  end

endmodule

// File: rtl/disp_issue_ctrl.sv
// Single-issue dispatch controller.
// Accepts one decoded instruction per cycle (dec), checks integer/FP RAW+WAW
// hazards, CSR serialization and in-flight capacity, holds the instruction
// in a one-entry issue register and presents it to the selected unit (iss,
// unit_valid_o/unit_ready_i). Writebacks release scoreboard bits, commits
// retire in-flight instructions, flush/reset clear all state.
// Ports: clk_i, srst_i, flush_i, dec (slave), iss (master), unit_valid_o,
// unit_ready_i, wb_valid_i/wb_rdindex_i, fwb_valid_i/fwb_rdindex_i,
// commit_i, idle_o.
module disp_issue_ctrl
  import prv664_disp_pkg::*;
#(
  parameter int unsigned UNITS        = DEFAULT_UNITS,
  parameter int unsigned MAX_INFLIGHT = DEFAULT_MAX_INFLIGHT
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  flush_i,
  pip_decode_interface.slave    dec,
  pip_decode_interface.master   iss,
  output logic [UNITS-1:0]      unit_valid_o,
  input  logic [UNITS-1:0]      unit_ready_i,
  input  logic                  wb_valid_i,
  input  reg_idx_t              wb_rdindex_i,
  input  logic                  fwb_valid_i,
  input  reg_idx_t              fwb_rdindex_i,
  input  logic                  commit_i,
  output logic                  idle_o
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic             occ_q;
  logic             occ_d;
  iss_op_t          op_q;
  iss_op_t          dec_op_c;
  logic [UNITS-1:0] dest_q;
  logic [CNT_W-1:0] inflight_q;
  logic [CNT_W-1:0] inflight_d;

  logic [NREGS-1:0] int_busy;
  logic [NREGS-1:0] int_ebusy_c;
  logic [NREGS-1:0] fp_busy;
  logic [NREGS-1:0] fp_ebusy_c;

  logic clear_c;
  logic int_haz_c;
  logic fp_haz_c;
  logic csr_haz_c;
  logic cap_haz_c;
  logic slot_free_c;
  logic ready_c;
  logic accept_c;
  logic issue_c;
  logic commit_ok_c;

  assign clear_c = srst_i | flush_i;

  // Scoreboards: x0 is never marked, FP register 0 is a real register
  disp_scoreboard u_int_sb (
    .clk     (clk_i),
    .srst    (clear_c),
    .set_en  (accept_c & dec.rden & (dec.rdindex != '0)),
    .set_idx (dec.rdindex),
    .clr_en  (wb_valid_i),
    .clr_idx (wb_rdindex_i),
    .busy    (int_busy),
    .ebusy_c (int_ebusy_c)
  );

  disp_scoreboard u_fp_sb (
    .clk     (clk_i),
    .srst    (clear_c),
    .set_en  (accept_c & dec.frden),
    .set_idx (dec.frdindex),
    .clr_en  (fwb_valid_i),
    .clr_idx (fwb_rdindex_i),
    .busy    (fp_busy),
    .ebusy_c (fp_ebusy_c)
  );

  // Machine fully drained: nothing held, nothing in flight, nothing pending
  assign idle_o = ~occ_q & (inflight_q == '0) & ~(|int_busy) & ~(|fp_busy);

  // Hazards look only at decode payload, never at dec.valid
  assign int_haz_c = (dec.rs1en & int_ebusy_c[dec.rs1index])
                   | (dec.rs2en & int_ebusy_c[dec.rs2index])
                   | (dec.rden  & int_ebusy_c[dec.rdindex]);

  assign fp_haz_c  = (dec.frs1en & fp_ebusy_c[dec.frs1index])
                   | (dec.frs2en & fp_ebusy_c[dec.frs2index])
                   | (dec.frs3en & fp_ebusy_c[dec.frs3index])
                   | (dec.frden  & fp_ebusy_c[dec.frdindex]);

  assign csr_haz_c = (dec.csren | dec.fflagen) & ~idle_o;

  // Held instruction counts against capacity; issue moves it from occ to
  // inflight, so the sum is unaffected by a same-cycle issue
  assign cap_haz_c = (SUM_W'(inflight_q) + SUM_W'(occ_q)) >= SUM_W'(MAX_INFLIGHT);

  assign issue_c     = occ_q & iss.ready;
  assign slot_free_c = ~occ_q | issue_c;
  assign ready_c     = slot_free_c & ~(int_haz_c | fp_haz_c | csr_haz_c | cap_haz_c)
                     & ~flush_i & ~srst_i;
  assign accept_c    = dec.valid & ready_c;
  assign dec.ready   = ready_c;

  // Underflowing commits are dropped so the counter saturates at zero
  assign commit_ok_c = commit_i & (inflight_q != '0);

  // Capture the decode payload in issue-register form
  always_comb begin
    dec_op_c           = '0;
    dec_op_c.pc        = dec.pc;
    dec_op_c.instr     = dec.instr;
    dec_op_c.rs1en     = dec.rs1en;
    dec_op_c.rs1index  = dec.rs1index;
    dec_op_c.rs2en     = dec.rs2en;
    dec_op_c.rs2index  = dec.rs2index;
    dec_op_c.rden      = dec.rden;
    dec_op_c.rdindex   = dec.rdindex;
    dec_op_c.frs1en    = dec.frs1en;
    dec_op_c.frs1index = dec.frs1index;
    dec_op_c.frs2en    = dec.frs2en;
    dec_op_c.frs2index = dec.frs2index;
    dec_op_c.frs3en    = dec.frs3en;
    dec_op_c.frs3index = dec.frs3index;
    dec_op_c.frden     = dec.frden;
    dec_op_c.frdindex  = dec.frdindex;
    dec_op_c.csren     = dec.csren;
    dec_op_c.fflagen   = dec.fflagen;
  end

  // Next-state for occupancy and in-flight count
  always_comb begin
    occ_d      = accept_c | (occ_q & ~issue_c);
    inflight_d = inflight_q;
    unique case ({issue_c, commit_ok_c})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Issue register and counter; payload only reloads on accept so it stays
  // stable while the selected unit back-pressures
  always_ff @(posedge clk_i) begin
    if (clear_c) begin
      occ_q      <= 1'b0;
      op_q       <= '0;
      dest_q     <= '0;
      inflight_q <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      if (accept_c) begin
        op_q   <= dec_op_c;
        dest_q <= dec.disp_dest;
      end
    end
  end

  // Issue side outputs straight from the register
  assign iss.valid     = occ_q;
  assign iss.ready     = |(unit_ready_i & dest_q);
  assign iss.disp_dest = dest_q;
  assign iss.pc        = op_q.pc;
  assign iss.instr     = op_q.instr;
  assign iss.rs1en     = op_q.rs1en;
  assign iss.rs1index  = op_q.rs1index;
  assign iss.rs2en     = op_q.rs2en;
  assign iss.rs2index  = op_q.rs2index;
  assign iss.rden      = op_q.rden;
  assign iss.rdindex   = op_q.rdindex;
  assign iss.frs1en    = op_q.frs1en;
  assign iss.frs1index = op_q.frs1index;
  assign iss.frs2en    = op_q.frs2en;
  assign iss.frs2index = op_q.frs2index;
  assign iss.frs3en    = op_q.frs3en;
  assign iss.frs3index = op_q.frs3index;
  assign iss.frden     = op_q.frden;
  assign iss.frdindex  = op_q.frdindex;
  assign iss.csren     = op_q.csren;
  assign iss.fflagen   = op_q.fflagen;

  assign unit_valid_o = {UNITS{occ_q}} & dest_q;

  // Retiring more than was issued is a protocol error upstream
  commit_underflow_a : assert property (
    @(posedge clk_i) disable iff (srst_i) !(commit_i && (inflight_q == '0))
  );

endmodule

// File: tb/tb_disp_issue_ctrl.sv
// Scoreboard bench for disp_issue_ctrl: the driver queues each instruction
// it expects to be accepted, a monitor compares every issue handshake
// against the queue head. Directed checks cover stalls and reset/flush.
module tb_disp_issue_ctrl;
  import prv664_disp_pkg::*;

  logic       clk = 1'b0;
  logic       srst;
  logic       flush;
  logic [3:0] unit_valid;
  logic [3:0] unit_ready;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       fwb_valid;
  logic [4:0] fwb_rd;
  logic       commit;
  logic       idle;

  always #5 clk = ~clk;

  pip_decode_interface dec_if ();
  pip_decode_interface iss_if ();

  disp_issue_ctrl dut (
    .clk_i         (clk),
    .srst_i        (srst),
    .flush_i       (flush),
    .dec           (dec_if),
    .iss           (iss_if),
    .unit_valid_o  (unit_valid),
    .unit_ready_i  (unit_ready),
    .wb_valid_i    (wb_valid),
    .wb_rdindex_i  (wb_rd),
    .fwb_valid_i   (fwb_valid),
    .fwb_rdindex_i (fwb_rd),
    .commit_i      (commit),
    .idle_o        (idle)
  );

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  dest;
    logic        rden;
    logic [4:0]  rd;
    logic        csren;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every issue handshake must match the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    if (iss_if.valid === 1'b1 && iss_if.ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_issue: got pc 0x%0h, expected no issue", iss_if.pc);
      end else begin
        e = exp_q.pop_front();
        check("issue_pc", iss_if.pc, e.pc);
        check("issue_unit_valid", 32'(unit_valid), 32'(e.dest));
        check("issue_rd", 32'({iss_if.rden, iss_if.rdindex}), 32'({e.rden, e.rd}));
        check("issue_csren", 32'(iss_if.csren), 32'(e.csren));
      end
    end
    if (srst || flush) exp_q.delete();
  end

  task automatic clear_op();
    dec_if.valid     = 1'b0;
    dec_if.disp_dest = '0;
    dec_if.pc        = '0;
    dec_if.instr     = '0;
    dec_if.rs1en     = 1'b0;
    dec_if.rs1index  = '0;
    dec_if.rs2en     = 1'b0;
    dec_if.rs2index  = '0;
    dec_if.rden      = 1'b0;
    dec_if.rdindex   = '0;
    dec_if.frs1en    = 1'b0;
    dec_if.frs1index = '0;
    dec_if.frs2en    = 1'b0;
    dec_if.frs2index = '0;
    dec_if.frs3en    = 1'b0;
    dec_if.frs3index = '0;
    dec_if.frden     = 1'b0;
    dec_if.frdindex  = '0;
    dec_if.csren     = 1'b0;
    dec_if.fflagen   = 1'b0;
  endtask

  task automatic set_op(input logic [31:0] pc, input logic [3:0] dest,
                        input logic rs1en, input logic [4:0] rs1,
                        input logic rs2en, input logic [4:0] rs2,
                        input logic rden, input logic [4:0] rd, input logic csr);
    clear_op();
    dec_if.valid     = 1'b1;
    dec_if.pc        = pc;
    dec_if.instr     = ~pc;
    dec_if.disp_dest = dest;
    dec_if.rs1en     = rs1en;
    dec_if.rs1index  = rs1;
    dec_if.rs2en     = rs2en;
    dec_if.rs2index  = rs2;
    dec_if.rden      = rden;
    dec_if.rdindex   = rd;
    dec_if.csren     = csr;
    cur = '{pc: pc, dest: dest, rden: rden, rd: rd, csren: csr};
  endtask

  task automatic set_fop(input logic [31:0] pc, input logic [3:0] dest,
                         input logic frs1en, input logic [4:0] frs1,
                         input logic frden, input logic [4:0] frd);
    clear_op();
    dec_if.valid     = 1'b1;
    dec_if.pc        = pc;
    dec_if.disp_dest = dest;
    dec_if.frs1en    = frs1en;
    dec_if.frs1index = frs1;
    dec_if.frden     = frden;
    dec_if.frdindex  = frd;
    cur = '{pc: pc, dest: dest, rden: 1'b0, rd: 5'd0, csren: 1'b0};
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Called at mid-cycle: the current op must be taken at the next edge
  task automatic take(input string name);
    check({name, "_ready"}, 32'(dec_if.ready), 32'd1);
    exp_q.push_back(cur);
    advance();
  endtask

  task automatic hold(input string name);
    check({name, "_stall"}, 32'(dec_if.ready), 32'd0);
    advance();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    srst       = 1'b1;
    flush      = 1'b0;
    unit_ready = 4'b1111;
    wb_valid   = 1'b0;
    wb_rd      = '0;
    fwb_valid  = 1'b0;
    fwb_rd     = '0;
    commit     = 1'b0;
    clear_op();
    dec_if.valid = 1'b1;
    repeat (2) advance();

    // Reset state
    mid();
    check("rst_dec_ready", 32'(dec_if.ready), 32'd0);
    check("rst_iss_valid", 32'(iss_if.valid), 32'd0);
    check("rst_unit_valid", 32'(unit_valid), 32'd0);
    check("rst_iss_pc", iss_if.pc, 32'd0);
    advance();
    srst = 1'b0;
    clear_op();
    mid();
    check("post_rst_idle", 32'(idle), 32'd1);
    advance();

    // addi x5 -> ALU, visible next cycle
    set_op(32'h100, 4'b0001, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0);
    mid(); take("addi_x5");
    // add x6,x5,x1 stalls on x5 until its writeback
    set_op(32'h104, 4'b0001, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b0);
    mid();
    check("addi_iss_valid", 32'(iss_if.valid), 32'd1);
    check("addi_unit_valid", 32'(unit_valid), 32'h1);
    hold("raw_x5");
    mid();
    check("raw_idle", 32'(idle), 32'd0);
    hold("raw_x5_again");
    wb_valid = 1'b1;
    wb_rd    = 5'd5;
    mid(); take("raw_wb_same_cycle");
    wb_valid = 1'b0;
    clear_op();
    mid();
    check("raw_issue_valid", 32'(iss_if.valid), 32'd1);
    check("raw_issue_pc", iss_if.pc, 32'h104);
    advance();

    // Write to x0 leaves it free for a dependent
    set_op(32'h108, 4'b0010, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
    mid(); take("wr_x0");
    set_op(32'h10c, 4'b0100, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    mid(); take("dep_x0");
    clear_op();

    // Retire two (inflight 3 -> 2 with the x0 dependent issuing) and release x6
    commit   = 1'b1;
    wb_valid = 1'b1;
    wb_rd    = 5'd6;
    advance();
    wb_valid = 1'b0;
    advance();
    commit = 1'b0;

    // CSR waits for a drained machine
    set_op(32'h200, 4'b0001, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b1);
    mid();
    check("csr_idle_busy", 32'(idle), 32'd0);
    hold("csr_inflight2");
    commit = 1'b1;
    mid(); hold("csr_commit1");
    mid(); hold("csr_commit2");
    commit = 1'b0;
    mid();
    check("csr_idle_drained", 32'(idle), 32'd1);
    take("csr_drained");
    clear_op();
    mid();
    check("csr_iss_valid", 32'(iss_if.valid), 32'd1);
    check("csr_unit0", 32'(unit_valid), 32'h1);
    advance();
    commit   = 1'b1;
    wb_valid = 1'b1;
    wb_rd    = 5'd8;
    advance();
    commit   = 1'b0;
    wb_valid = 1'b0;
    mid();
    check("csr_retired_idle", 32'(idle), 32'd1);
    advance();

    // Capacity: 16 back-to-back, the 17th waits for a commit
    for (int i = 0; i < 16; i++) begin
      set_op(32'h400 + 32'(i) * 4, 4'(1 << (i % 4)), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      mid(); take($sformatf("burst%0d", i));
    end
    set_op(32'h500, 4'b0010, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
    mid(); hold("cap_full_a");
    mid(); hold("cap_full_b");
    commit = 1'b1;
    mid(); hold("cap_commit_cycle");
    commit = 1'b0;
    mid(); take("cap_after_commit");

    // Back-pressure keeps the held instruction stable
    clear_op();
    unit_ready = 4'b0000;
    mid();
    check("bp_valid", 32'(iss_if.valid), 32'd1);
    check("bp_unit_valid", 32'(unit_valid), 32'h2);
    advance();
    mid();
    check("bp_pc_stable", iss_if.pc, 32'h500);
    advance();

    // Flush with a concurrent writeback
    flush    = 1'b1;
    wb_valid = 1'b1;
    wb_rd    = 5'd9;
    set_op(32'h600, 4'b0001, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    mid(); hold("flush_blocks_accept");
    flush      = 1'b0;
    wb_valid   = 1'b0;
    unit_ready = 4'b1111;
    clear_op();
    mid();
    check("flush_iss_valid", 32'(iss_if.valid), 32'd0);
    check("flush_unit_valid", 32'(unit_valid), 32'd0);
    check("flush_idle", 32'(idle), 32'd1);
    advance();
    set_op(32'h604, 4'b0001, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 5'd10, 1'b0);
    mid(); take("post_flush_x9_free");

    // FP register 0 is tracked; FP writeback unblocks same cycle
    set_fop(32'h700, 4'b1000, 1'b0, 5'd0, 1'b1, 5'd0);
    mid(); take("fp_write_f0");
    set_fop(32'h704, 4'b1000, 1'b1, 5'd0, 1'b0, 5'd0);
    mid(); hold("fp_raw_f0");
    fwb_valid = 1'b1;
    fwb_rd    = 5'd0;
    mid(); take("fp_wb_same_cycle");
    fwb_valid = 1'b0;
    clear_op();
    repeat (3) advance();

    mid();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_issue_ctrl.md
# disp_issue_ctrl

Single-issue dispatch controller between the decode stage and the execution units. It accepts one decoded instruction per cycle on the decode handshake and checks it against an integer/FP register scoreboard. Hazard-free instructions are held in a one-entry issue register, and the unit selected by `disp_dest` is signalled. It tracks in-flight instructions, releases scoreboard bits on writeback, serializes CSR instructions and clears everything on flush.

## Interface
Parameters:
- UNITS, 4: number of execution units; `disp_dest` is one-hot over bits [UNITS-1:0].
- MAX_INFLIGHT, 16: maximum issued-but-not-committed instructions.

Ports:
- clk_i  in  1  single clock, all state on rising edge.
- srst_i  in  1  reset, synchronous and active-high.
- flush_i  in  1  pipeline flush, same effect as reset on all state.
- dec  slave  pip_decode_interface.slave  decoded instruction in (valid/ready).
- iss  master  pip_decode_interface.master  issued instruction out; all fields are copies of the accepted decode fields.
- unit_valid_o  out  UNITS  per-unit valid, equal to `iss.valid & iss.disp_dest[i]`.
- unit_ready_i  in  UNITS  per-unit ready; `iss.ready` is driven internally as `|(unit_ready_i & iss.disp_dest)`.
- wb_valid_i  in  1  integer writeback; clears busy[wb_rdindex_i].
- wb_rdindex_i  in  5  integer writeback register.
- fwb_valid_i  in  1  FP writeback; clears fbusy[fwb_rdindex_i].
- fwb_rdindex_i  in  5  FP writeback register.
- commit_i  in  1  one instruction retired; decrements the in-flight count.
- idle_o  out  1  asserted when the issue register is empty, in-flight is 0 and all busy bits are clear.

## Operation
- State:
  - busy[31:0] and fbusy[31:0] scoreboards.
  - Issue register with valid bit `occ`.
  - inflight counter, width $clog2(MAX_INFLIGHT+1).
- Effective busy: the busy bit AND NOT the same-cycle writeback clear for that index. A writeback therefore unblocks in the same cycle.
- Hazard (combinational, on the dec fields):
  - Integer: rs1en&ebusy[rs1index] | rs2en&ebusy[rs2index] | rden&ebusy[rdindex], i.e. RAW and WAW.
  - FP: frs1/frs2/frs3/frd, checked the same way against fbusy.
  - CSR: csren or fflagen, and NOT idle_o. CSR instructions issue only into a fully drained machine.
  - Capacity: inflight + occ ≥ MAX_INFLIGHT.
- Slot free: !occ, or (occ & iss.ready).
- `dec.ready` = slot free & !hazard & !flush_i & !srst_i.
- Accept (dec.valid & dec.ready):
  - Load the issue register and set occ.
  - Set busy[rdindex] if rden and rdindex≠0. Register x0 is never marked busy.
  - Set fbusy[frdindex] if frden. FP register 0 is marked.
- Issue (occ & iss.ready): inflight +1. If no accept in the same cycle, occ clears.
- Same-index writeback clear and accept set in one cycle: the set wins.
- Commit while inflight=0 is a protocol error. inflight holds at 0 (saturates), and this is flagged by an assertion.
- Simultaneous issue and commit: inflight is unchanged.
- Flush or reset: occ, busy, fbusy and inflight go to 0 next cycle. Writebacks arriving in the same cycle are ignored.

## Timing
- Reset values: iss.valid=0, unit_valid_o=0, all iss fields 0, busy=fbusy=0, inflight=0, dec.ready=0 during reset, idle_o=1 the cycle after reset.
- Latency: decode accept in cycle N makes iss.valid=1 in cycle N+1.
- Throughput: 1 instruction/cycle when units are ready and there are no hazards.
- iss fields and valid are stable while iss.valid & !iss.ready. Standard valid/ready: valid never depends on ready.
- dec.ready depends combinationally on wb_valid_i, fwb_valid_i and iss.ready. There is no combinational path from dec.valid to dec.ready.
- Back-to-back dependent instructions: the consumer stalls until a writeback of the producer's rd. It is accepted in the writeback cycle at the earliest.

## Structure
- Shared package `prv664_disp_pkg`:
  - UNITS and MAX_INFLIGHT defaults.
  - Unit-index constants: ALU=0, LSU=1, MDU=2, FPU=3.
  - Typedef of the issue-register struct mirroring the decode fields.
- Natural sub-module `disp_scoreboard` (32-entry busy vector with set/clear/effective-read ports), instantiated twice: integer and FP.
- Everything else stays in the top module.

## Test plan
- Reset, then send `addi x5` (rden, rd=5, disp_dest=4'b0001) -> iss.valid next cycle, unit_valid_o=0001, busy[5]=1.
- Send `add x6,x5,x1` with no writeback -> dec.ready=0. Assert wb_valid_i with rd=5 -> accepted that same cycle, and the instruction issues the next cycle.
- Write with rd=x0 -> busy stays 0; a dependent on x0 is accepted immediately.
- CSR instruction while inflight=2 -> stalled. Two commits -> accepted in the cycle idle_o=1; issued on unit 0 one cycle later.
- MAX_INFLIGHT=16: issue 16 with no commit -> the 17th stalls. One commit -> it is accepted.
- Hold unit_ready_i=0 with iss.valid=1, then assert flush_i -> iss.valid=0, busy=0, inflight=0 next cycle; same-cycle wb ignored.
